io_bus_arbiter: RTL and testbench

- Two-master Wishbone arbiter in front of the I/O controller slave port.
- Shares the single I/O bus (17-bit address, 32-bit data) between the CPU (master 0) and a DMA/debug master (master 1).
- Uses round-robin fairness and holds ownership for locked multi-access cycles.
- An optional watchdog aborts transfers the slave never acknowledges.

---
 rtl/io_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Two-master Wishbone arbiter for the I/O controller slave port.
// Master 0 is the CPU, master 1 the DMA/debug master. Round-robin under
// contention; an owner keeps the bus while its cyc stays high (locked cycles).
// Optional watchdog build: define IO_BUS_ARBITER_WATCHDOG_EN to abort strobes
// that are never acknowledged within TIMEOUT cycles.
module io_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter bit          M0_FIRST = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // Master 0 (CPU)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [16:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // Master 1 (DMA/debug)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [16:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // Slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [16:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  // One-hot owner, 00 = idle
  output logic [1:0]  grant
);

  // Reject out-of-range watchdog limits at elaboration.
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : gen_bad_timeout
    $error("io_bus_arbiter: TIMEOUT must be in 2..65535");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  // 1 = master 1 owned the bus last, so master 0 wins the next contention.
  logic   last_q, last_d;
  logic   own0, own1;
  logic   sel_cyc, sel_stb;
  logic   timeout_hit;

`ifdef IO_BUS_ARBITER_WATCHDOG_EN
  localparam logic [15:0] WdLast = 16'(TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;
`endif

  assign own0 = (state_q == StOwn0);
  assign own1 = (state_q == StOwn1);

  // Owner's cyc/stb as seen before any watchdog abort masking.
  assign sel_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign sel_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

`ifdef IO_BUS_ARBITER_WATCHDOG_EN
  assign timeout_hit = sel_stb & ~s_ack_i & (wd_q == WdLast);
`else
  assign timeout_hit = 1'b0;
`endif

  // Slave-side mux and master-side responses; zero-latency pass-through.
  always_comb begin
    s_cyc_o  = sel_cyc & ~timeout_hit;
    s_stb_o  = sel_stb & ~timeout_hit;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    if (own0) begin
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (own1) begin
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
    // An ack arriving after the owner dropped cyc belongs to an aborted cycle.
    m0_ack_o = own0 & m0_cyc_i & s_ack_i;
    m1_ack_o = own1 & m1_cyc_i & s_ack_i;
    m0_err_o = own0 & timeout_hit;
    m1_err_o = own1 & timeout_hit;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    grant    = {own1, own0};
  end

  // Ownership decision and watchdog next-state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (m0_cyc_i) begin
          state_d = StOwn0;
        end else if (m1_cyc_i) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!m0_cyc_i || timeout_hit) begin
          state_d = StIdle;
          last_d  = 1'b0;
        end
      end
      StOwn1: begin
        if (!m1_cyc_i || timeout_hit) begin
          state_d = StIdle;
          last_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef IO_BUS_ARBITER_WATCHDOG_EN
    // Held at zero in idle so every ownership starts from a clean count.
    wd_d = wd_q;
    if (state_q == StIdle || s_ack_i) begin
      wd_d = '0;
    end else if (sel_stb) begin
      wd_d = wd_q + 16'd1;
    end
`endif
  end

  // State registers; reset drops ownership, and with it the slave strobes, at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= M0_FIRST;
`ifdef IO_BUS_ARBITER_WATCHDOG_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef IO_BUS_ARBITER_WATCHDOG_EN
      wd_q    <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter. Inputs change 1 ns after a rising edge;
// outputs are checked 1 ns later, well clear of the next edge.
module tb_io_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [16:0] m0_adr_i;
  logic [31:0] m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [16:0] m1_adr_i;
  logic [31:0] m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [16:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  io_bus_arbiter #(
    .TIMEOUT (16),
    .M0_FIRST(1'b1)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .m0_cyc_i(m0_cyc_i),
    .m0_stb_i(m0_stb_i),
    .m0_we_i (m0_we_i),
    .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i),
    .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i),
    .m1_stb_i(m1_stb_i),
    .m1_we_i (m1_we_i),
    .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i),
    .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .grant   (grant)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    m0_adr_i = '0;   m0_dat_i = '0;   m0_sel_i = 4'hF;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    m1_adr_i = '0;   m1_dat_i = '0;   m1_sel_i = 4'hF;
    s_dat_i  = '0;   s_ack_i  = 1'b0;
  endtask

  initial begin
    logic seen_err;
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    check("rst_s_stb", 32'(s_stb_o), 32'd0);
    check("rst_acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single read by master 0, slave acks two cycles after the strobe.
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 17'h01000;
    #1;
    check("t1_req_grant", 32'(grant), 32'd0);
    check("t1_req_s_cyc", 32'(s_cyc_o), 32'd0);
    step(); #1;
    check("t1_grant", 32'(grant), 32'd1);
    check("t1_s_stb", 32'(s_stb_o), 32'd1);
    check("t1_s_adr", 32'(s_adr_o), 32'h01000);
    check("t1_ack_wait0", 32'(m0_ack_o), 32'd0);
    step(); #1;
    check("t1_ack_wait1", 32'(m0_ack_o), 32'd0);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'h0000ABCD;
    #1;
    check("t1_m0_ack", 32'(m0_ack_o), 32'd1);
    check("t1_m0_dat", m0_dat_o, 32'h0000ABCD);
    check("t1_m1_ack", 32'(m1_ack_o), 32'd0);
    step();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    check("t1_ack_pulse", 32'(m0_ack_o), 32'd0);
    check("t1_drop_s_cyc", 32'(s_cyc_o), 32'd0);
    step(); #1;
    check("t1_idle", 32'(grant), 32'd0);

    // Contention from reset: owners alternate 01,10,01,10 with idle between.
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 17'h00100;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 17'h00200;
    for (int i = 0; i < 4; i++) begin
      automatic int own = i % 2;
      #1;
      check("t2_idle_grant", 32'(grant), 32'd0);
      step();
      s_ack_i = 1'b1; s_dat_i = 32'(i);
      #1;
      check("t2_grant", 32'(grant), (own == 1) ? 32'd2 : 32'd1);
      check("t2_s_adr", 32'(s_adr_o), (own == 1) ? 32'h00200 : 32'h00100);
      check("t2_own_ack", 32'(own == 1 ? m1_ack_o : m0_ack_o), 32'd1);
      check("t2_other_ack", 32'(own == 1 ? m0_ack_o : m1_ack_o), 32'd0);
      step();
      s_ack_i = 1'b0;
      if (own == 1) begin
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      end else begin
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      end
      #1;
      check("t2_drop_s_cyc", 32'(s_cyc_o), 32'd0);
      step();
      if (i < 3) begin
        if (own == 1) begin
          m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        end else begin
          m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        end
      end else begin
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      end
    end
    #1;
    check("t2_final_idle", 32'(grant), 32'd0);

    // Master 1 locked across three writes while master 0 waits.
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_adr_i = 17'h06000; m1_dat_i = 32'h11111111;
    #1;
    check("t3_req_grant", 32'(grant), 32'd0);
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 17'h02000;
    s_ack_i = 1'b1;
    #1;
    check("t3_grant_w0", 32'(grant), 32'd2);
    check("t3_adr_w0", 32'(s_adr_o), 32'h06000);
    check("t3_we", 32'(s_we_o), 32'd1);
    check("t3_dat", s_dat_o, 32'h11111111);
    check("t3_m1_ack", 32'(m1_ack_o), 32'd1);
    check("t3_m0_ack", 32'(m0_ack_o), 32'd0);
    step();
    m1_adr_i = 17'h06004;
    #1;
    check("t3_grant_w1", 32'(grant), 32'd2);
    check("t3_adr_w1", 32'(s_adr_o), 32'h06004);
    step();
    m1_adr_i = 17'h06008;
    #1;
    check("t3_grant_w2", 32'(grant), 32'd2);
    check("t3_adr_w2", 32'(s_adr_o), 32'h06008);
    step();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; s_ack_i = 1'b0;
    #1;
    check("t3_drop_grant", 32'(grant), 32'd2);
    check("t3_drop_s_cyc", 32'(s_cyc_o), 32'd0);
    step(); #1;
    check("t3_dead_cycle", 32'(grant), 32'd0);
    step(); #1;
    check("t3_m0_grant", 32'(grant), 32'd1);
    check("t3_m0_adr", 32'(s_adr_o), 32'h02000);

    // Master 0 abandons its access; a late ack reaches nobody.
    step();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    check("t4_s_cyc_falls", 32'(s_cyc_o), 32'd0);
    step();
    s_ack_i = 1'b1;
    #1;
    check("t4_late_ack", 32'({m0_ack_o, m1_ack_o}), 32'd0);
    check("t4_idle", 32'(grant), 32'd0);
    step();
    s_ack_i = 1'b0;

    // Slave never acknowledges.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 17'h03000;
    step(); #1;
    check("t5_grant", 32'(grant), 32'd1);
    check("t5_s_stb", 32'(s_stb_o), 32'd1);
`ifdef IO_BUS_ARBITER_WATCHDOG_EN
    seen_err = 1'b0;
    for (int k = 1; k < 15; k++) begin
      step(); #1;
      if (m0_err_o) seen_err = 1'b1;
    end
    check("t5_no_early_err", 32'(seen_err), 32'd0);
    step(); #1;
    check("t5_err", 32'(m0_err_o), 32'd1);
    check("t5_err_ack", 32'(m0_ack_o), 32'd0);
    check("t5_abort_s_cyc", 32'(s_cyc_o), 32'd0);
    check("t5_abort_s_stb", 32'(s_stb_o), 32'd0);
    step(); #1;
    check("t5_err_pulse", 32'(m0_err_o), 32'd0);
    check("t5_after_s_cyc", 32'(s_cyc_o), 32'd0);
    check("t5_after_grant", 32'(grant), 32'd0);
    step(); #1;
    check("t5_rearb_grant", 32'(grant), 32'd1);
    check("t5_rearb_s_cyc", 32'(s_cyc_o), 32'd1);
`else
    seen_err = 1'b0;
    repeat (1000) begin
      step(); #1;
      if (m0_err_o || m1_err_o) seen_err = 1'b1;
    end
    check("t5_no_err", 32'(seen_err), 32'd0);
    check("t5_still_stb", 32'(s_stb_o), 32'd1);
    check("t5_still_grant", 32'(grant), 32'd1);
`endif
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
    step();

    // Asynchronous reset in the middle of a master 1 write.
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 17'h06010;
    step(); #1;
    check("t6_grant", 32'(grant), 32'd2);
    check("t6_s_cyc", 32'(s_cyc_o), 32'd1);
    s_ack_i = 1'b1;
    #1;
    check("t6_m1_ack", 32'(m1_ack_o), 32'd1);
    #1;
    rst_i = 1'b1;
    #1;
    check("t6_rst_s_cyc", 32'(s_cyc_o), 32'd0);
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
    idle_inputs();
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    #1;
    check("t6_req_grant", 32'(grant), 32'd0);
    step(); #1;
    check("t6_first_contention", 32'(grant), 32'd1);
    idle_inputs();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
